seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl_if.sv | 24 ++
 rtl/seg_scan_ctrl.sv | 95 +++++++++
 tb/tb_seg_scan_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// Write-request bundle for the two requesters of seg_scan_ctrl.
// Ports: a_*/b_* valid, idx, data (requester -> ctrl), a_ready/b_ready (ctrl -> requester).
interface seg_scan_ctrl_if;
    logic       a_valid;
    logic [1:0] a_idx;
    logic [3:0] a_data;
    logic       a_ready;
    logic       b_valid;
    logic [1:0] b_idx;
    logic [3:0] b_data;
    logic       b_ready;

    modport master (
        output a_valid, a_idx, a_data,
        output b_valid, b_idx, b_data,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_idx, a_data,
        input  b_valid, b_idx, b_data,
        output a_ready, b_ready
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan controller with a 2-requester
// round-robin write port into the digit register file.
// Ports: clk, reset (sync, active-low), bus (slave: a/b write handshakes),
//        blank_mask (per-digit blank), digit_sel, digit_data, anode
//        (active-low), scan_tick (end-of-digit-period pulse).
module seg_scan_ctrl #(
    parameter int DIV_W = 15,
    parameter int GUARD = 8
) (
    input  logic          clk,
    input  logic          reset,
    seg_scan_ctrl_if.slave bus,
    input  logic [3:0]    blank_mask,
    output logic [1:0]    digit_sel,
    output logic [3:0]    digit_data,
    output logic [3:0]    anode,
    output logic          scan_tick
);

    localparam logic [DIV_W-1:0] GUARD_LD = DIV_W'(GUARD);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_guard;
    logic [1:0]       r_sel;
    logic [3:0]       r_digit [4];
    // 0: A wins a tie, 1: B wins a tie
    logic             r_ptr;

    logic             w_tick;
    logic             w_a_gnt;
    logic             w_b_gnt;
    logic             w_wr;
    logic [1:0]       w_wr_idx;
    logic [3:0]       w_wr_data;
    logic [3:0]       w_anode_on;
    logic             w_blank;

    assign w_tick = reset && (r_div == '1);

    // Grants are gated by reset so nothing handshakes in a reset cycle.
    assign w_a_gnt = reset && bus.a_valid && (!bus.b_valid || !r_ptr);
    assign w_b_gnt = reset && bus.b_valid && (!bus.a_valid ||  r_ptr);

    assign w_wr      = w_a_gnt || w_b_gnt;
    assign w_wr_idx  = w_a_gnt ? bus.a_idx  : bus.b_idx;
    assign w_wr_data = w_a_gnt ? bus.a_data : bus.b_data;

    assign bus.a_ready = w_a_gnt;
    assign bus.b_ready = w_b_gnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div   <= '0;
            r_sel   <= '0;
            r_guard <= GUARD_LD;
            r_ptr   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_digit[i] <= '0;
            end
        end else begin
            r_div <= r_div + DIV_W'(1);
            if (w_tick) begin
                r_sel   <= r_sel + 2'd1;
                r_guard <= GUARD_LD;
            end else if (r_guard != '0) begin
                r_guard <= r_guard - DIV_W'(1);
            end
            if (w_wr) begin
                r_digit[w_wr_idx] <= w_wr_data;
                // hand the tie-break to whoever did not just win
                r_ptr <= w_a_gnt;
            end
        end
    end

    always_comb begin
        w_anode_on = 4'b1111;
        unique case (r_sel)
            2'd0: w_anode_on = 4'b0111;
            2'd1: w_anode_on = 4'b1011;
            2'd2: w_anode_on = 4'b1101;
            2'd3: w_anode_on = 4'b1110;
        endcase
    end

    // Guard window keeps all anodes off right after a digit switch
    // so the previous digit's segments cannot ghost onto the new one.
    assign w_blank = blank_mask[r_sel] || (r_guard != '0);

    assign anode      = w_blank ? 4'b1111 : w_anode_on;
    assign digit_sel  = r_sel;
    assign digit_data = r_digit[r_sel];
    assign scan_tick  = w_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (DIV_W=4, GUARD=2 plus a
// GUARD=0 instance); write results go through a scoreboard queue.
module tb_seg_scan_ctrl;

    localparam int DIV_W = 4;
    localparam int GUARD = 2;
    localparam int PER   = 16;

    typedef struct {
        logic [1:0] idx;
        logic [3:0] data;
    } wr_t;

    logic       clk;
    logic       reset;
    logic [3:0] blank_mask;
    logic [1:0] digit_sel;
    logic [3:0] digit_data;
    logic [3:0] anode;
    logic       scan_tick;
    logic [1:0] sel0;
    logic [3:0] data0;
    logic [3:0] anode0;
    logic       tick0;

    int  n_cmp;
    int  n_fail;
    wr_t sb[$];

    seg_scan_ctrl_if bus ();
    seg_scan_ctrl_if bus0 ();

    seg_scan_ctrl #(.DIV_W(DIV_W), .GUARD(GUARD)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .blank_mask (blank_mask),
        .digit_sel  (digit_sel),
        .digit_data (digit_data),
        .anode      (anode),
        .scan_tick  (scan_tick)
    );

    seg_scan_ctrl #(.DIV_W(DIV_W), .GUARD(0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus0.slave),
        .blank_mask (4'b0000),
        .digit_sel  (sel0),
        .digit_data (data0),
        .anode      (anode0),
        .scan_tick  (tick0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] dec(input logic [1:0] s);
        case (s)
            2'd0:    return 4'b0111;
            2'd1:    return 4'b1011;
            2'd2:    return 4'b1101;
            default: return 4'b1110;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.a_valid = 1'b0;
        bus.a_idx   = 2'd0;
        bus.a_data  = 4'd0;
        bus.b_valid = 1'b0;
        bus.b_idx   = 2'd0;
        bus.b_data  = 4'd0;
    endtask

    // Leaves the bench in the first cycle after release (divider = 0).
    task automatic do_reset();
        reset = 1'b0;
        nxt();
        nxt();
        reset = 1'b1;
    endtask

    task automatic scan_check(input int ncyc, input logic [3:0] mask);
        for (int k = 0; k < ncyc; k++) begin
            logic [1:0] es;
            logic [3:0] ea;
            logic       et;
            es = 2'((k / PER) % 4);
            et = ((k % PER) == PER - 1);
            ea = (((k % PER) < GUARD) || mask[es]) ? 4'hF : dec(es);
            #3;
            chk("scan_sel",   32'(digit_sel),  32'(es));
            chk("scan_tick",  32'(scan_tick),  32'(et));
            chk("scan_anode", 32'(anode),      32'(ea));
            chk("scan_data",  32'(digit_data), 32'(0));
            chk("g0_sel",     32'(sel0),       32'(es));
            chk("g0_anode",   32'(anode0),     32'(dec(es)));
            nxt();
        end
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            wr_t e;
            int  n;
            e = sb.pop_front();
            n = 0;
            #3;
            while (digit_sel !== e.idx && n < 80) begin
                nxt();
                #3;
                n++;
            end
            chk("sb_wait", 32'(n < 80), 32'(1));
            if (n < 80) chk("sb_data", 32'(digit_data), 32'(e.data));
            nxt();
        end
    endtask

    initial begin
        int  n;
        wr_t w;
        n_cmp      = 0;
        n_fail     = 0;
        reset      = 1'b0;
        blank_mask = 4'b0000;
        idle_bus();
        bus0.a_valid = 1'b0;
        bus0.a_idx   = 2'd0;
        bus0.a_data  = 4'd0;
        bus0.b_valid = 1'b0;
        bus0.b_idx   = 2'd0;
        bus0.b_data  = 4'd0;

        // ready forced low during reset even with valids up
        nxt();
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        #1;
        chk("rst_a_ready", 32'(bus.a_ready), 32'(0));
        chk("rst_b_ready", 32'(bus.b_ready), 32'(0));
        idle_bus();
        do_reset();

        // free-running scan, five periods
        scan_check(5 * PER, 4'b0000);

        // single write from A
        bus.a_valid = 1'b1;
        bus.a_idx   = 2'd2;
        bus.a_data  = 4'd9;
        #1;
        chk("a_only_a", 32'(bus.a_ready), 32'(1));
        chk("a_only_b", 32'(bus.b_ready), 32'(0));
        w.idx = 2'd2; w.data = 4'd9; sb.push_back(w);
        nxt();
        idle_bus();
        #1;
        chk("idle_a", 32'(bus.a_ready), 32'(0));
        chk("idle_b", 32'(bus.b_ready), 32'(0));
        drain();

        // single write from B
        bus.b_valid = 1'b1;
        bus.b_idx   = 2'd3;
        bus.b_data  = 4'd7;
        #1;
        chk("b_only_b", 32'(bus.b_ready), 32'(1));
        chk("b_only_a", 32'(bus.a_ready), 32'(0));
        w.idx = 2'd3; w.data = 4'd7; sb.push_back(w);
        nxt();
        idle_bus();
        drain();

        // contention on idx 0, starting three cycles after release
        do_reset();
        nxt();
        nxt();
        nxt();
        bus.a_valid = 1'b1; bus.a_idx = 2'd0; bus.a_data = 4'd1;
        bus.b_valid = 1'b1; bus.b_idx = 2'd0; bus.b_data = 4'd5;
        #1;
        chk("ct1_a", 32'(bus.a_ready), 32'(1));
        chk("ct1_b", 32'(bus.b_ready), 32'(0));
        nxt();
        #1;
        chk("ct2_a", 32'(bus.a_ready), 32'(0));
        chk("ct2_b", 32'(bus.b_ready), 32'(1));
        chk("ct2_reg0", 32'(digit_data), 32'(1));
        nxt();
        #1;
        chk("ct3_a", 32'(bus.a_ready), 32'(1));
        chk("ct3_b", 32'(bus.b_ready), 32'(0));
        chk("ct3_reg0", 32'(digit_data), 32'(5));
        nxt();
        idle_bus();
        #1;
        chk("ct_end_reg0", 32'(digit_data), 32'(1));

        // pointer now favours B; different targets
        bus.a_valid = 1'b1; bus.a_idx = 2'd1; bus.a_data = 4'd2;
        bus.b_valid = 1'b1; bus.b_idx = 2'd3; bus.b_data = 4'd6;
        #1;
        chk("rr1_b", 32'(bus.b_ready), 32'(1));
        chk("rr1_a", 32'(bus.a_ready), 32'(0));
        w.idx = 2'd3; w.data = 4'd6; sb.push_back(w);
        nxt();
        #1;
        chk("rr2_a", 32'(bus.a_ready), 32'(1));
        chk("rr2_b", 32'(bus.b_ready), 32'(0));
        w.idx = 2'd1; w.data = 4'd2; sb.push_back(w);
        nxt();
        idle_bus();
        drain();

        // blanking of digit 2 only
        do_reset();
        blank_mask = 4'b0100;
        scan_check(4 * PER, 4'b0100);
        blank_mask = 4'b0000;

        // mid-operation reset during digit 3 at the tick cycle
        bus.a_valid = 1'b1; bus.a_idx = 2'd3; bus.a_data = 4'hC;
        nxt();
        idle_bus();
        n = 0;
        while (!(digit_sel === 2'd3 && scan_tick === 1'b1) && n < 80) begin
            nxt();
            n++;
        end
        chk("mr_wait", 32'(n < 80), 32'(1));
        chk("mr_pre_reg3", 32'(digit_data), 32'(4'hC));
        reset = 1'b0;
        bus.a_valid = 1'b1; bus.a_idx = 2'd3; bus.a_data = 4'hA;
        bus.b_valid = 1'b1; bus.b_idx = 2'd1; bus.b_data = 4'h3;
        #1;
        chk("mr_a_ready", 32'(bus.a_ready), 32'(0));
        chk("mr_b_ready", 32'(bus.b_ready), 32'(0));
        chk("mr_tick",    32'(scan_tick),   32'(0));
        nxt();
        reset = 1'b1;
        idle_bus();
        #1;
        chk("mr_sel", 32'(digit_sel), 32'(0));
        chk("mr_anode", 32'(anode), 32'(4'hF));
        #1;
        scan_check(4 * PER, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
